// File: rtl/sync_fifo_status.sv
// sync_fifo_status: single-clock FIFO with occupancy count, thresholds, error pulses, flush and optional FWFT
module sync_fifo_status #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 32,
   parameter int AF_THRESH  = DEPTH - 4,
   parameter int AE_THRESH  = 4,
   parameter int FWFT       = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       w_en,
   input  logic                       r_en,
   input  logic [DATA_WIDTH-1:0]      data_in,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEP = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF  = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] AE  = (AW+1)'(AE_THRESH);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] head_n;
   logic [AW:0] wr_ptr, rd_ptr, wr_n, rd_n, cnt_n;
   logic wr_ok, rd_ok;
   // accept decisions, next pointers/count, and the word that will sit at the head after this edge
   always_comb begin
      rd_ok  = r_en && !empty;
      wr_ok  = w_en && (!full || rd_ok);
      wr_n   = wr_ptr + (AW+1)'(wr_ok);
      rd_n   = rd_ptr + (AW+1)'(rd_ok);
      cnt_n  = count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      head_n = (wr_ok && rd_n == wr_ptr) ? data_in : mem[rd_n[AW-1:0]];
   end
   // storage write; contents survive clear and reset
   always_ff @(posedge clk)
      if (rst_n && !clear && wr_ok) mem[wr_ptr[AW-1:0]] <= data_in;
   // pointers, occupancy, registered flags, error pulses and read data
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
         data_out     <= '0;
      end else if (clear) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
         data_out     <= '0;
      end else begin
         wr_ptr       <= wr_n;
         rd_ptr       <= rd_n;
         count        <= cnt_n;
         full         <= cnt_n == DEP;
         empty        <= cnt_n == '0;
         almost_full  <= cnt_n >= AF;
         almost_empty <= cnt_n <= AE;
         overflow     <= w_en && full && !rd_ok;
         underflow    <= r_en && empty;
         if (FWFT != 0) begin
            if (cnt_n != '0) data_out <= head_n;
         end else if (rd_ok) data_out <= mem[rd_ptr[AW-1:0]];
      end
endmodule

// File: tb/tb_sync_fifo_status.sv
// tb_sync_fifo_status: directed checks of a standard-mode and an FWFT-mode FIFO instance
module tb_sync_fifo_status;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0, w_en = 1'b0, r_en = 1'b0;
   logic [7:0] data_in = '0, data_out;
   logic full, empty, almost_full, almost_empty, overflow, underflow;
   logic [5:0] count;
   logic f_clear = 1'b0, f_w_en = 1'b0, f_r_en = 1'b0;
   logic [7:0] f_data_in = '0, f_data_out;
   logic f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
   logic [5:0] f_count;
   int tests = 0, fails = 0;

   sync_fifo_status #(.DATA_WIDTH(8), .DEPTH(32), .AF_THRESH(28), .AE_THRESH(4), .FWFT(0)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .w_en(w_en), .r_en(r_en), .data_in(data_in),
      .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow));

   sync_fifo_status #(.DATA_WIDTH(8), .DEPTH(32), .AF_THRESH(28), .AE_THRESH(4), .FWFT(1)) dut_f (
      .clk(clk), .rst_n(rst_n), .clear(f_clear), .w_en(f_w_en), .r_en(f_r_en), .data_in(f_data_in),
      .data_out(f_data_out), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
      .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_count"}, count, 0);
      check({tag, "_empty"}, empty, 1);
      check({tag, "_full"}, full, 0);
      check({tag, "_af"}, almost_full, 0);
      check({tag, "_ae"}, almost_empty, 1);
      check({tag, "_dout"}, data_out, 0);
      check({tag, "_ovf"}, overflow, 0);
      check({tag, "_unf"}, underflow, 0);
   endtask

   initial begin
      step();
      step();
      check_reset("rst");
      check("rst_f_empty", f_empty, 1);
      check("rst_f_dout", f_data_out, 0);
      rst_n = 1'b1;
      // fill 0x00..0x1F
      for (int i = 0; i < 32; i++) begin
         w_en = 1'b1;
         data_in = 8'(i);
         step();
         check("fill_count", count, i + 1);
         check("fill_empty", empty, 0);
         check("fill_af", almost_full, (i + 1) >= 28);
         check("fill_full", full, (i + 1) == 32);
      end
      // overflow for two cycles
      data_in = 8'hAA;
      for (int i = 0; i < 2; i++) begin
         step();
         check("ovf_pulse", overflow, 1);
         check("ovf_count", count, 32);
      end
      w_en = 1'b0;
      step();
      check("ovf_end", overflow, 0);
      // standard-mode drain
      for (int k = 0; k < 32; k++) begin
         r_en = 1'b1;
         step();
         check("drain_dout", data_out, k);
         check("drain_count", count, 31 - k);
         check("drain_ae", almost_empty, (31 - k) <= 4);
         check("drain_empty", empty, k == 31);
         check("drain_full", full, 0);
      end
      step();
      check("unf_pulse", underflow, 1);
      check("unf_hold", data_out, 8'h1F);
      check("unf_count", count, 0);
      r_en = 1'b0;
      step();
      check("unf_end", underflow, 0);
      // simultaneous read+write on empty
      w_en = 1'b1;
      r_en = 1'b1;
      data_in = 8'h33;
      step();
      check("se_count", count, 1);
      check("se_unf", underflow, 1);
      check("se_dout", data_out, 8'h1F);
      r_en = 1'b0;
      for (int i = 0; i < 31; i++) begin
         data_in = 8'(8'h80 + i);
         step();
      end
      check("refill_full", full, 1);
      // simultaneous read+write on full
      r_en = 1'b1;
      data_in = 8'h55;
      step();
      check("sf_count", count, 32);
      check("sf_dout", data_out, 8'h33);
      check("sf_ovf", overflow, 0);
      check("sf_full", full, 1);
      w_en = 1'b0;
      for (int k = 0; k < 32; k++) begin
         step();
         check("sf_drain", data_out, (k == 31) ? 8'h55 : 8'(8'h80 + k));
      end
      r_en = 1'b0;
      step();
      // clear at count 10 with a write pending
      w_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         data_in = 8'(8'hC0 + i);
         step();
      end
      check("pre_clear_count", count, 10);
      clear = 1'b1;
      step();
      clear = 1'b0;
      w_en = 1'b0;
      check_reset("clr");
      // asynchronous reset mid-burst
      w_en = 1'b1;
      r_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         data_in = 8'(8'hE0 + i);
         step();
      end
      check("burst_empty", empty, 0);
      check("burst_dout", data_out, 8'hE3);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("arst");
      w_en = 1'b0;
      r_en = 1'b0;
      #2;
      rst_n = 1'b1;
      step();
      check("post_arst_count", count, 0);
      // FWFT: single word into empty
      f_w_en = 1'b1;
      f_data_in = 8'h77;
      step();
      f_w_en = 1'b0;
      check("fw_dout", f_data_out, 8'h77);
      check("fw_empty", f_empty, 0);
      check("fw_count", f_count, 1);
      step();
      check("fw_stay", f_data_out, 8'h77);
      f_r_en = 1'b1;
      step();
      f_r_en = 1'b0;
      check("fw_pop_empty", f_empty, 1);
      check("fw_pop_count", f_count, 0);
      check("fw_pop_hold", f_data_out, 8'h77);
      // FWFT: two words, head stays until popped
      f_w_en = 1'b1;
      f_data_in = 8'h11;
      step();
      check("fw2_first", f_data_out, 8'h11);
      f_data_in = 8'h22;
      step();
      f_w_en = 1'b0;
      check("fw2_head", f_data_out, 8'h11);
      check("fw2_count", f_count, 2);
      f_r_en = 1'b1;
      step();
      check("fw2_next", f_data_out, 8'h22);
      check("fw2_cnt1", f_count, 1);
      step();
      f_r_en = 1'b0;
      check("fw2_empty", f_empty, 1);
      check("fw2_hold", f_data_out, 8'h22);
      step();
      check("fw2_unf", f_underflow, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
